// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage controller.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam int unsigned CNT_W = 8;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_branch_resolve.sv
// Combinational branch/jump decision and redirect target selection.
module branch_resolve
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH = 32
) (
    input  logic              en,
    input  logic              bbeq,
    input  logic              bbne,
    input  logic              bblez,
    input  logic              bbgtz,
    input  logic              jump,
    input  logic              zero,
    input  logic              negative,
    input  logic [AWIDTH-1:0] branaddr,
    input  logic [AWIDTH-1:0] jmpaddr,
    output logic [1:0]        pcsrc_c,
    output logic [AWIDTH-1:0] target_c,
    output logic              flush_c
);

    logic taken;

    always_comb begin
        pcsrc_c  = PCSRC_SEQ;
        target_c = '0;
        taken    = (bbeq & zero) | (bbne & ~zero) |
                   (bblez & (zero | negative)) | (bbgtz & ~zero & ~negative);
        if (en) begin
            if (jump) begin
                pcsrc_c  = PCSRC_JUMP;
                target_c = jmpaddr;
            end else if (taken) begin
                pcsrc_c  = PCSRC_BRANCH;
                target_c = branaddr;
            end
        end
        flush_c = (pcsrc_c != PCSRC_SEQ);
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: one data-memory transaction per load/store with stall,
// load-data return, bus-error tracking and branch/jump redirect.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              memrdin,
    input  logic              memwrin,
    input  logic              bbeqin,
    input  logic              bbnein,
    input  logic              bblezin,
    input  logic              bbgtzin,
    input  logic              jumpin,
    input  logic              zeroin,
    input  logic              negativein,
    input  logic [DWIDTH-1:0] aluoutin,
    input  logic [DWIDTH-1:0] regdata2in,
    input  logic [AWIDTH-1:0] branaddrin,
    input  logic [AWIDTH-1:0] jmpaddrin,
    output logic              dmreq,
    output logic              dmwe,
    output logic [AWIDTH-1:0] dmaddr,
    output logic [DWIDTH-1:0] dmwdata,
    input  logic [DWIDTH-1:0] dmrdata,
    input  logic              dmack,
    output logic              stallout,
    output logic [DWIDTH-1:0] rdataout,
    output logic              rdatavalid,
    output logic [1:0]        pcsrcout,
    output logic [AWIDTH-1:0] pctargetout,
    output logic              flushout,
    output logic              buserrout
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0]  addr_q, addr_d;
    logic [DWIDTH-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [DWIDTH-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               buserr_q, buserr_d;
    logic               stall_c;
    logic               branch_en_c;
    logic               mem_op_c;

    assign mem_op_c = memrdin | memwrin;

    // Next-state, counter and capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        buserr_d    = buserr_q;
        stall_c     = 1'b0;
        branch_en_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op_c) begin
                    if (!word_aligned(aluoutin[1:0])) begin
                        buserr_d = 1'b1;
                    end else begin
                        addr_d  = AWIDTH'(aluoutin);
                        wdata_d = regdata2in;
                        we_d    = memwrin;
                        cnt_d   = '0;
                        stall_c = 1'b1;
                        state_d = ST_REQ;
                    end
                end else begin
                    branch_en_c = 1'b1;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // An ack in the timeout cycle still completes the access.
                if (dmack) begin
                    if (!we_q) begin
                        rdata_d  = dmrdata;
                        rvalid_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    buserr_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            buserr_q <= buserr_d;
        end
    end

    branch_resolve #(
        .AWIDTH (AWIDTH)
    ) u_branch_resolve (
        .en       (branch_en_c),
        .bbeq     (bbeqin),
        .bbne     (bbnein),
        .bblez    (bblezin),
        .bbgtz    (bbgtzin),
        .jump     (jumpin),
        .zero     (zeroin),
        .negative (negativein),
        .branaddr (branaddrin),
        .jmpaddr  (jmpaddrin),
        .pcsrc_c  (pcsrcout),
        .target_c (pctargetout),
        .flush_c  (flushout)
    );

    assign dmreq      = (state_q == ST_REQ);
    assign dmwe       = we_q;
    assign dmaddr     = addr_q;
    assign dmwdata    = wdata_q;
    assign rdataout   = rdata_q;
    assign rdatavalid = rvalid_q;
    assign buserrout  = buserr_q;
    assign stallout   = stall_c;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: transaction-level model compared every cycle.
module tb_mem_stage_ctrl;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          memrdin = 1'b0, memwrin = 1'b0;
    logic          bbeqin = 1'b0, bbnein = 1'b0, bblezin = 1'b0, bbgtzin = 1'b0;
    logic          jumpin = 1'b0, zeroin = 1'b0, negativein = 1'b0;
    logic [DW-1:0] aluoutin = '0, regdata2in = '0;
    logic [AW-1:0] branaddrin = '0, jmpaddrin = '0;
    logic          dmreq, dmwe;
    logic [AW-1:0] dmaddr;
    logic [DW-1:0] dmwdata;
    logic [DW-1:0] dmrdata = '0;
    logic          dmack = 1'b0;
    logic          stallout;
    logic [DW-1:0] rdataout;
    logic          rdatavalid;
    logic [1:0]    pcsrcout;
    logic [AW-1:0] pctargetout;
    logic          flushout, buserrout;

    mem_stage_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .memrdin(memrdin), .memwrin(memwrin),
        .bbeqin(bbeqin), .bbnein(bbnein), .bblezin(bblezin), .bbgtzin(bbgtzin),
        .jumpin(jumpin), .zeroin(zeroin), .negativein(negativein),
        .aluoutin(aluoutin), .regdata2in(regdata2in),
        .branaddrin(branaddrin), .jmpaddrin(jmpaddrin),
        .dmreq(dmreq), .dmwe(dmwe), .dmaddr(dmaddr), .dmwdata(dmwdata),
        .dmrdata(dmrdata), .dmack(dmack), .stallout(stallout),
        .rdataout(rdataout), .rdatavalid(rdatavalid), .pcsrcout(pcsrcout),
        .pctargetout(pctargetout), .flushout(flushout), .buserrout(buserrout)
    );

    always #5 clk = ~clk;

    // Transaction model: an access is outstanding, then one settle cycle, then free.
    bit            m_busy = 1'b0, m_settle = 1'b0, m_we = 1'b0, m_rvalid = 1'b0, m_err = 1'b0;
    int            m_waited = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 1'b0; m_settle = 1'b0; m_we = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
            m_waited = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            m_rvalid = 1'b0;
            if (m_busy) begin
                m_waited = m_waited + 1;
                if (dmack) begin
                    m_busy = 1'b0; m_settle = 1'b1;
                    if (!m_we) begin m_rdata = dmrdata; m_rvalid = 1'b1; end
                end else if (m_waited == int'(TMO)) begin
                    m_busy = 1'b0; m_settle = 1'b1; m_err = 1'b1;
                end
            end else if (m_settle) begin
                m_settle = 1'b0;
            end else if (memrdin || memwrin) begin
                if (aluoutin % 4 != 0) m_err = 1'b1;
                else begin
                    m_busy = 1'b1; m_waited = 0; m_addr = aluoutin;
                    m_wdata = regdata2in; m_we = memwrin;
                end
            end
        end
    end

    int n_checks = 0, n_fail = 0;
    int stall_cnt = 0, req_cnt = 0, rv_cnt = 0;
    int s0, r0, v0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on the falling edge.
    task automatic compare_model();
        bit       free, memop, taken;
        logic [1:0]    e_src;
        logic [AW-1:0] e_tgt;
        free  = !m_busy && !m_settle;
        memop = memrdin || memwrin;
        taken = 1'b0;
        if (bbeqin && zeroin) taken = 1'b1;
        if (bbnein && !zeroin) taken = 1'b1;
        if (bblezin && (zeroin || negativein)) taken = 1'b1;
        if (bbgtzin && !zeroin && !negativein) taken = 1'b1;
        e_src = 2'd0; e_tgt = '0;
        if (free && !memop) begin
            if (jumpin) begin e_src = 2'd2; e_tgt = jmpaddrin; end
            else if (taken) begin e_src = 2'd1; e_tgt = branaddrin; end
        end
        check("dmreq", 64'(dmreq), 64'(m_busy));
        check("dmwe", 64'(dmwe), 64'(m_we));
        check("dmaddr", 64'(dmaddr), 64'(m_addr));
        check("dmwdata", 64'(dmwdata), 64'(m_wdata));
        check("rdataout", 64'(rdataout), 64'(m_rdata));
        check("rdatavalid", 64'(rdatavalid), 64'(m_rvalid));
        check("buserrout", 64'(buserrout), 64'(m_err));
        check("stallout", 64'(stallout),
              64'(m_busy || (free && memop && aluoutin[1:0] == 2'b00)));
        check("pcsrcout", 64'(pcsrcout), 64'(e_src));
        check("pctargetout", 64'(pctargetout), 64'(e_tgt));
        check("flushout", 64'(flushout), 64'(e_src != 2'd0));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        stall_cnt += int'(stallout);
        req_cnt   += int'(dmreq);
        rv_cnt    += int'(rdatavalid);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        memrdin = 0; memwrin = 0; bbeqin = 0; bbnein = 0; bblezin = 0; bbgtzin = 0;
        jumpin = 0; zeroin = 0; negativein = 0; aluoutin = '0; regdata2in = '0;
        dmack = 0;
    endtask

    task automatic snap();
        s0 = stall_cnt; r0 = req_cnt; v0 = rv_cnt;
    endtask

    initial begin
        tick();
        check("reset_dmreq", 64'(dmreq), 64'd0);
        check("reset_rdataout", 64'(rdataout), 64'd0);
        check("reset_buserr", 64'(buserrout), 64'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Load at 0x100, ack in third request cycle
        snap();
        memrdin = 1; aluoutin = 32'h100;
        tick(); tick(); tick();
        dmack = 1; dmrdata = 32'hDEADBEEF;
        tick();
        dmack = 0;
        tick();
        clear_inputs();
        tick();
        check("load_stall_cycles", 64'(stall_cnt - s0), 64'd4);
        check("load_req_cycles", 64'(req_cnt - r0), 64'd3);
        check("load_rvalid_pulses", 64'(rv_cnt - v0), 64'd1);
        check("load_rdata", 64'(rdataout), 64'hDEADBEEF);

        // Store 0x12345678 to 0x204, immediate ack
        snap();
        memwrin = 1; aluoutin = 32'h204; regdata2in = 32'h12345678;
        tick();
        dmack = 1;
        check("store_dmwe", 64'(dmwe), 64'd1);
        check("store_dmaddr", 64'(dmaddr), 64'h204);
        check("store_dmwdata", 64'(dmwdata), 64'h12345678);
        tick();
        dmack = 0;
        tick();
        clear_inputs();
        tick();
        check("store_stall_cycles", 64'(stall_cnt - s0), 64'd2);
        check("store_rvalid_pulses", 64'(rv_cnt - v0), 64'd0);
        check("store_rdata_kept", 64'(rdataout), 64'hDEADBEEF);

        // Branch and jump resolution
        branaddrin = 32'h40; jmpaddrin = 32'h80;
        bbeqin = 1; zeroin = 1; #1;
        check("beq_pcsrc", 64'(pcsrcout), 64'd1);
        check("beq_target", 64'(pctargetout), 64'h40);
        check("beq_flush", 64'(flushout), 64'd1);
        tick();
        bbeqin = 0; zeroin = 0; bbgtzin = 1; negativein = 1; #1;
        check("bgtz_neg_pcsrc", 64'(pcsrcout), 64'd0);
        check("bgtz_neg_flush", 64'(flushout), 64'd0);
        tick();
        bbgtzin = 0; jumpin = 1; bbeqin = 1; zeroin = 1; #1;
        check("jump_pcsrc", 64'(pcsrcout), 64'd2);
        check("jump_target", 64'(pctargetout), 64'h80);
        tick();
        jumpin = 0; bbeqin = 0; zeroin = 0; bbnein = 1; tick();
        bbnein = 0; bblezin = 1; negativein = 1; tick();
        bblezin = 0; bbgtzin = 1; negativein = 0; tick();
        clear_inputs();
        tick();

        // Load with no ack: timeout after TMO request cycles
        snap();
        memrdin = 1; aluoutin = 32'h300;
        tick(); tick(); tick(); tick();
        check("tmo_no_err_yet", 64'(buserrout), 64'd0);
        tick();
        check("tmo_buserr", 64'(buserrout), 64'd1);
        check("tmo_rdata_kept", 64'(rdataout), 64'hDEADBEEF);
        tick();
        clear_inputs();
        tick();
        check("tmo_req_cycles", 64'(req_cnt - r0), 64'(TMO));
        check("tmo_rvalid_pulses", 64'(rv_cnt - v0), 64'd0);

        rstn = 0; tick(); rstn = 1; tick();
        check("buserr_cleared", 64'(buserrout), 64'd0);

        // Misaligned load: no request, sticky error
        snap();
        memrdin = 1; aluoutin = 32'h102; #1;
        check("misal_stall", 64'(stallout), 64'd0);
        tick();
        clear_inputs();
        tick();
        check("misal_buserr", 64'(buserrout), 64'd1);
        check("misal_no_req", 64'(req_cnt - r0), 64'd0);
        memrdin = 1; aluoutin = 32'h108;
        tick();
        dmack = 1; dmrdata = 32'hCAFEF00D;
        tick();
        dmack = 0;
        tick();
        clear_inputs();
        tick();
        check("sticky_buserr", 64'(buserrout), 64'd1);
        check("second_load_rdata", 64'(rdataout), 64'hCAFEF00D);

        // Reset in the middle of a request; late ack must be ignored
        memrdin = 1; aluoutin = 32'h400;
        tick(); tick();
        rstn = 0; memrdin = 0; aluoutin = '0; #1;
        check("rst_dmreq", 64'(dmreq), 64'd0);
        check("rst_stall", 64'(stallout), 64'd0);
        check("rst_rvalid", 64'(rdatavalid), 64'd0);
        check("rst_buserr", 64'(buserrout), 64'd0);
        tick();
        rstn = 1;
        snap();
        dmack = 1; dmrdata = 32'h55555555;
        tick();
        dmack = 0;
        tick(); tick();
        check("late_ack_rdata", 64'(rdataout), 64'd0);
        check("late_ack_rvalid", 64'(rv_cnt - v0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
